// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default bit timing.
// The default timing matches the project transmitter (100 MHz clock, 115200 baud).
package uart_rx_pkg;

    localparam int unsigned CLK_PER_BIT_DEFAULT = 868;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to RESET_VAL, so an idle-high line reads idle straight out of reset.
module uart_rx_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, sampling each bit at mid-period.
// One bit period is CLK_PER_BIT+1 clocks, identical to the project transmitter.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    output logic [7:0] rdata,
    output logic       rx_ready,
    output logic       ferr,
    output logic       busy,
    output state_t     dbg_state
);

    localparam logic [31:0] LAST = 32'(CLK_PER_BIT);
    localparam logic [31:0] HALF = 32'(CLK_PER_BIT / 2);

    logic        rs;
    state_t      state;
    logic [31:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  sr;

    uart_rx_sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk (clk),
        .rstn(rstn),
        .d   (rxd),
        .q   (rs)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            sr       <= '0;
            rdata    <= '0;
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            rx_ready <= 1'b0;
            cnt      <= cnt + 32'd1;
            case (state)
                S_IDLE: begin
                    if (!rs) begin
                        state <= S_START;
                        cnt   <= '0;
                    end
                end
                // Re-check the start bit at its middle; a high line here was a glitch.
                S_START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (!rs) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (cnt == LAST) begin
                        sr      <= {rs, sr[7:1]};
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rs) begin
                            rdata    <= sr;
                            rx_ready <= 1'b1;
                            ferr     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            ferr  <= 1'b1;
                            state <= S_BREAK;
                        end
                    end
                end
                // A line held low must return high before another start bit counts.
                S_BREAK: begin
                    if (rs) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_PER_BIT=15 (16-clock bits, half period 7).
// A behavioural 8N1 transmitter drives rxd; a monitor collects every rx_ready pulse.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int CPB = 15;
    localparam int P   = CPB + 1;
    localparam int H   = CPB / 2;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd  = 1'b1;
    logic [7:0] rdata;
    logic       rx_ready;
    logic       ferr;
    logic       busy;
    state_t     dbg_state;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    int         start_cyc;
    bit         ferr_seen;
    logic [7:0] got_q[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLK_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .rxd      (rxd),
        .rdata    (rdata),
        .rx_ready (rx_ready),
        .ferr     (ferr),
        .busy     (busy),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rx_ready) begin
            got_q.push_back(rdata);
            got_cyc.push_back(cyc);
        end
        if (ferr) ferr_seen = 1'b1;
    end

    // Drives one 8N1 frame starting at the current negedge; rxd is left at the stop level.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        start_cyc = cyc;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (P) @(negedge clk);
        end
        rxd = stop;
        repeat (P) @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rxd  = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
        n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL reset_rx_ready: got %b expected 0", rx_ready); end
        n_cmp++; if (ferr !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, S_IDLE); end
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        int lat_exp;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        ferr_seen = 1'b0;
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        rxd = 1'b1;
        repeat (P) @(negedge clk);
        // 2 synchroniser flops + 1 detect edge, then H+9P+1 from the FSM seeing rs low.
        lat_exp = start_cyc + 3 + H + 9 * P + 1;
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL single_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL single_data: got %h expected %h", got_q[0], exp_q[0]); end
            n_cmp++; if (got_cyc[0] != lat_exp) begin n_bad++; $display("FAIL single_latency: got cycle %0d expected %0d", got_cyc[0], lat_exp); end
        end
        n_cmp++; if (rdata !== 8'h55) begin n_bad++; $display("FAIL single_hold: got %h expected 55", rdata); end
        n_cmp++; if (ferr_seen !== 1'b0) begin n_bad++; $display("FAIL single_ferr: got %b expected 0", ferr_seen); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] g;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        ferr_seen = 1'b0;
        exp_q.push_back(8'hA3); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        foreach (exp_q[i]) send_byte(exp_q[i], 1'b1);
        rxd = 1'b1;
        repeat (P) @(negedge clk);
        n_cmp++; if (got_q.size() != 3) begin n_bad++; $display("FAIL b2b_count: got %0d expected 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            g = 8'hxx;
            if (i < got_q.size()) g = got_q[i];
            n_cmp++; if (g !== exp_q[i]) begin n_bad++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, g, exp_q[i]); end
        end
        n_cmp++; if (ferr_seen !== 1'b0) begin n_bad++; $display("FAIL b2b_ferr: got %b expected 0", ferr_seen); end
    endtask

    task automatic test_glitch();
        int hi_cnt;
        got_q.delete(); got_cyc.delete();
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        hi_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (busy) hi_cnt++;
        end
        n_cmp++; if (hi_cnt < 1 || hi_cnt > 10) begin n_bad++; $display("FAIL glitch_busy_cycles: got %0d expected 1..10", hi_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
        n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL glitch_state: got %0d expected %0d", dbg_state, S_IDLE); end
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL glitch_no_pulse: got %0d expected 0", got_q.size()); end
        send_byte(8'h3C, 1'b1);
        rxd = 1'b1;
        repeat (P) @(negedge clk);
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL glitch_next_count: got %0d expected 1", got_q.size()); end
        n_cmp++; if (rdata !== 8'h3C) begin n_bad++; $display("FAIL glitch_next_data: got %h expected 3c", rdata); end
    endtask

    task automatic test_framing();
        got_q.delete(); got_cyc.delete();
        send_byte(8'h81, 1'b0);
        repeat (100) @(negedge clk);
        n_cmp++; if (ferr !== 1'b1) begin n_bad++; $display("FAIL frame_ferr: got %b expected 1", ferr); end
        n_cmp++; if (dbg_state !== S_BREAK) begin n_bad++; $display("FAIL frame_state: got %0d expected %0d", dbg_state, S_BREAK); end
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL frame_no_pulse: got %0d expected 0", got_q.size()); end
        n_cmp++; if (rdata !== 8'h3C) begin n_bad++; $display("FAIL frame_rdata_kept: got %h expected 3c", rdata); end
        rxd = 1'b1;
        repeat (P) @(negedge clk);
        n_cmp++; if (dbg_state !== S_IDLE) begin n_bad++; $display("FAIL break_release_state: got %0d expected %0d", dbg_state, S_IDLE); end
        n_cmp++; if (ferr !== 1'b1) begin n_bad++; $display("FAIL ferr_sticky: got %b expected 1", ferr); end
        n_cmp++; if (got_q.size() != 0) begin n_bad++; $display("FAIL break_no_pulse: got %0d expected 0", got_q.size()); end
        send_byte(8'h5A, 1'b1);
        rxd = 1'b1;
        repeat (P) @(negedge clk);
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL frame_recover_count: got %0d expected 1", got_q.size()); end
        n_cmp++; if (rdata !== 8'h5A) begin n_bad++; $display("FAIL frame_recover_data: got %h expected 5a", rdata); end
        n_cmp++; if (ferr !== 1'b0) begin n_bad++; $display("FAIL frame_recover_ferr: got %b expected 0", ferr); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'hC7;
        got_q.delete(); got_cyc.delete();
        rxd = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            repeat (P) @(negedge clk);
        end
        rxd = b[4];
        repeat (P / 2) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_frame_busy: got %b expected 1", busy); end
        rstn = 1'b0;
        #1;
        n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL mid_reset_rdata: got %h expected 00", rdata); end
        n_cmp++; if (rx_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_rx_ready: got %b expected 0", rx_ready); end
        n_cmp++; if (ferr !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ferr: got %b expected 0", ferr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (P) @(negedge clk);
        send_byte(8'h12, 1'b1);
        rxd = 1'b1;
        repeat (P) @(negedge clk);
        n_cmp++; if (got_q.size() != 1) begin n_bad++; $display("FAIL mid_reset_pulses: got %0d expected 1", got_q.size()); end
        n_cmp++; if (rdata !== 8'h12) begin n_bad++; $display("FAIL mid_reset_next_data: got %h expected 12", rdata); end
    endtask

    task automatic test_loopback();
        logic [7:0] g;
        got_q.delete(); got_cyc.delete(); exp_q.delete();
        ferr_seen = 1'b0;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        rxd = 1'b1;
        repeat (P) @(negedge clk);
        n_cmp++; if (got_q.size() != 256) begin n_bad++; $display("FAIL loop_count: got %0d expected 256", got_q.size()); end
        for (int i = 0; i < 256; i++) begin
            g = 8'hxx;
            if (i < got_q.size()) g = got_q[i];
            n_cmp++; if (g !== exp_q[i]) begin n_bad++; $display("FAIL loop_data[%0d]: got %h expected %h", i, g, exp_q[i]); end
        end
        n_cmp++; if (ferr_seen !== 1'b0) begin n_bad++; $display("FAIL loop_ferr: got %b expected 0", ferr_seen); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_mid_frame();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
